// File: rtl/cotm32_pkg.sv
// Shared core package: ROM map, access-size encoding and read-only-data arbiter types.
package cotm32_pkg;
  localparam int XLEN       = 32;
  localparam int BYTE_WIDTH = 8;

  localparam logic [XLEN-1:0] ROM_MEM_START = 32'h0002_0000;
  localparam logic [XLEN-1:0] ROM_MEM_SIZE  = 32'h0000_0400;
  localparam logic [XLEN-1:0] ROM_MEM_END   = ROM_MEM_START + ROM_MEM_SIZE - 1;
  localparam int              ROM_ADDR_W    = $clog2(ROM_MEM_SIZE);

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    RA_IDLE = 1'b0,
    RA_RESP = 1'b1
  } rodata_arb_state_t;

  // Request as seen by the shared access path after the grant mux.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [1:0]      size;
    logic            uns;
  } rodata_req_t;

  // The illegal size encoding is sized as a word; it errors out regardless.
  function automatic logic [2:0] size_bytes(logic [1:0] size);
    case (size)
      MEM_BYTE: return 3'd1;
      MEM_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction
endpackage

// File: rtl/rodata_arbiter_if.sv
// Two-port request/response bundle between the ROM clients and rodata_arbiter.
interface rodata_arbiter_if;
  import cotm32_pkg::*;

  logic [1:0]            i_req_valid;
  logic [1:0]            o_req_ready;
  logic [1:0][XLEN-1:0]  i_req_addr;
  logic [1:0][1:0]       i_req_size;
  logic [1:0]            i_req_unsigned;
  logic [1:0]            o_rsp_valid;
  logic [1:0]            i_rsp_ready;
  logic [XLEN-1:0]       o_rsp_rdata;
  logic                  o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_size, i_req_unsigned, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_size, i_req_unsigned, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/rodata_mem.sv
// Read-only data ROM with a purely combinational, word-aligned read port.
module rodata_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int IDX_W = ADDR_WIDTH - 2;

  // Word 0 is the fixed boot signature; the rest is a per-index pattern.
  function automatic logic [DATA_WIDTH-1:0] rom_word(logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'(idx);
    if (idx == '0) return DATA_WIDTH'(32'h80FF_7F01);
    return DATA_WIDTH'({~b, b, b ^ 8'h3C, b ^ 8'h96});
  endfunction

  logic unused_lane;
  assign unused_lane = ^addr[1:0];

  assign rdata = rom_word(addr[ADDR_WIDTH-1:2]);
endmodule

// File: rtl/rodata_arbiter.sv
// Two-port arbiter/access controller in front of the read-only data ROM.
module rodata_arbiter
  import cotm32_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  rodata_arbiter_if.slave bus
);
  rodata_arb_state_t state;
  logic              owner;
  logic              last_gnt;
  logic [1:0]        rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;

  logic              free;
  logic              gnt;
  logic [1:0]        req_ready;
  logic              accept;
  rodata_req_t       req;

  logic [XLEN-1:0]   offset;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [XLEN-1:0]   word;
  logic              unused_offset;

  logic [XLEN:0]     last_byte;
  logic              in_range;
  logic              misalign;
  logic              err;
  logic [BYTE_WIDTH-1:0]   byte_v;
  logic [2*BYTE_WIDTH-1:0] half_v;
  logic              sext;
  logic [XLEN-1:0]   ext;

  // A held response that is being taken this cycle frees the slot for a back-to-back accept.
  always_comb begin
    free = (state == RA_IDLE) || (rsp_valid[owner] && bus.i_rsp_ready[owner]);
    if (&bus.i_req_valid) gnt = FIXED_PRIO ? 1'b0 : ~last_gnt;
    else                  gnt = bus.i_req_valid[1];
    req_ready      = '0;
    req_ready[gnt] = free & bus.i_req_valid[gnt];
  end

  assign accept = |req_ready;

  always_comb begin
    req.addr = bus.i_req_addr[gnt];
    req.size = bus.i_req_size[gnt];
    req.uns  = bus.i_req_unsigned[gnt];
  end

  assign offset        = req.addr - ROM_MEM_START;
  assign rom_addr      = {offset[ROM_ADDR_W-1:2], 2'b00};
  assign unused_offset = ^{offset[XLEN-1:ROM_ADDR_W], offset[1:0]};

  rodata_mem #(
    .DATA_WIDTH (XLEN),
    .ADDR_WIDTH (ROM_ADDR_W)
  ) u_mem (
    .addr  (rom_addr),
    .rdata (word)
  );

  // Range check in XLEN+1 bits so an access straddling the top of the address space cannot wrap.
  always_comb begin
    last_byte = {1'b0, req.addr} + {{(XLEN-2){1'b0}}, size_bytes(req.size)} - (XLEN+1)'(1);
    in_range  = (req.addr >= ROM_MEM_START) && (last_byte <= {1'b0, ROM_MEM_END});
    case (req.size)
      MEM_HALF: misalign = req.addr[0];
      MEM_WORD: misalign = |req.addr[1:0];
      default:  misalign = 1'b0;
    endcase
    err = !in_range || misalign || (req.size == 2'b11);
  end

  always_comb begin
    byte_v = word[{req.addr[1:0], 3'b000} +: BYTE_WIDTH];
    half_v = word[{req.addr[1], 4'b0000} +: 2*BYTE_WIDTH];
    sext   = ~req.uns;
    case (req.size)
      MEM_BYTE: ext = {{(XLEN-BYTE_WIDTH){sext & byte_v[BYTE_WIDTH-1]}}, byte_v};
      MEM_HALF: ext = {{(XLEN-2*BYTE_WIDTH){sext & half_v[2*BYTE_WIDTH-1]}}, half_v};
      default:  ext = word;
    endcase
    if (err) ext = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RA_IDLE;
      owner     <= 1'b0;
      last_gnt  <= 1'b1;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      state     <= RA_RESP;
      owner     <= gnt;
      last_gnt  <= gnt;
      rsp_valid <= gnt ? 2'b10 : 2'b01;
      rsp_rdata <= ext;
      rsp_err   <= err;
    end else if (free) begin
      state     <= RA_IDLE;
      rsp_valid <= '0;
    end
  end

  assign bus.o_req_ready = req_ready;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;
endmodule

// File: tb/tb_rodata_arbiter.sv
// Directed plus randomized checks of rodata_arbiter against a behavioural ROM/arbiter model.
module tb_rodata_arbiter;
  import cotm32_pkg::*;

  localparam logic [31:0] S = ROM_MEM_START;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rodata_arbiter_if bus ();
  rodata_arbiter_if bus_f ();

  assign bus_f.i_req_valid    = bus.i_req_valid;
  assign bus_f.i_req_addr     = bus.i_req_addr;
  assign bus_f.i_req_size     = bus.i_req_size;
  assign bus_f.i_req_unsigned = bus.i_req_unsigned;
  assign bus_f.i_rsp_ready    = bus.i_rsp_ready;

  rodata_arbiter #(.FIXED_PRIO(1'b0)) dut   (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  rodata_arbiter #(.FIXED_PRIO(1'b1)) dut_f (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_f));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rom_img(int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 0) return 32'h80FF_7F01;
    return {~b, b, b ^ 8'h3C, b ^ 8'h96};
  endfunction

  // Returns {err, rdata} for one access, from the address map and size rules.
  function automatic logic [32:0] ref_read(logic [31:0] a, logic [1:0] sz, logic u);
    longint ad, n, v, lo, hi;
    ad = a; lo = ROM_MEM_START; hi = ROM_MEM_END;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (sz == 2'd3 || ad % n != 0 || ad < lo || ad + n - 1 > hi) return {1'b1, 32'd0};
    v = longint'(rom_img(int'((ad - lo) / 4)));
    v = (v >> (8 * (ad % 4))) % (longint'(1) << (8 * n));
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return {1'b0, v[31:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0:       return ROM_MEM_END - $urandom_range(0, 6);
      1:       return ROM_MEM_START - $urandom_range(1, 6);
      2:       return $urandom;
      3:       return 32'hFFFF_FFFC + $urandom_range(0, 3);
      default: return ROM_MEM_START + $urandom_range(0, 63);
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_req_valid = '0;
    bus.i_rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Single transaction from idle; called at posedge+1, returns at posedge+1 with the block idle.
  task automatic read1(input string tag, input int p, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [32:0] exp);
    bus.i_req_valid[p] = 1'b1; bus.i_req_addr[p] = a;
    bus.i_req_size[p] = sz; bus.i_req_unsigned[p] = u; bus.i_rsp_ready = 2'b00;
    #1 chk({tag, "_rdy"}, bus.o_req_ready, 2'b01 << p);
    @(posedge clk); #1;
    bus.i_req_valid[p] = 1'b0;
    chk({tag, "_vld"}, bus.o_rsp_valid, 2'b01 << p);
    chk({tag, "_dat"}, bus.o_rsp_rdata, exp[31:0]);
    chk({tag, "_err"}, bus.o_rsp_err, exp[32]);
    bus.i_rsp_ready = 2'b11;
    @(posedge clk); #1;
    bus.i_rsp_ready = 2'b00;
  endtask

  logic [1:0]  pend;
  logic [31:0] p_addr [2];
  logic [1:0]  p_size [2];
  logic        p_uns  [2];
  logic        m_vld, m_own, m_last, m_err, free, pick;
  logic [31:0] m_dat;
  logic [1:0]  exp_rdy;
  int          cnt;

  initial begin
    bus.i_req_addr = '0; bus.i_req_size = '0; bus.i_req_unsigned = '0;
    do_reset();
    chk("rst_vld", bus.o_rsp_valid, 2'b00);
    chk("rst_dat", bus.o_rsp_rdata, 32'd0);
    chk("rst_err", bus.o_rsp_err, 1'b0);
    chk("rst_rdy", bus.o_req_ready, 2'b00);

    read1("w0",    0, S,     2'd2, 1'b0, {1'b0, 32'h80FF_7F01});
    read1("b1u",   0, S + 1, 2'd0, 1'b1, {1'b0, 32'h0000_007F});
    read1("b3s",   0, S + 3, 2'd0, 1'b0, {1'b0, 32'hFFFF_FF80});
    read1("h2s",   0, S + 2, 2'd1, 1'b0, {1'b0, 32'hFFFF_80FF});
    read1("h0u",   0, S,     2'd1, 1'b1, {1'b0, 32'h0000_7F01});
    read1("h1",    0, S + 1, 2'd1, 1'b0, {1'b1, 32'd0});
    read1("w2",    0, S + 2, 2'd2, 1'b0, {1'b1, 32'd0});
    read1("wend",  0, ROM_MEM_END - 1, 2'd2, 1'b0, {1'b1, 32'd0});
    read1("sz3",   0, S,     2'd3, 1'b0, {1'b1, 32'd0});
    read1("below", 0, S - 4, 2'd2, 1'b0, {1'b1, 32'd0});
    read1("p1b5",  1, S + 5, 2'd0, 1'b0, ref_read(S + 5, 2'd0, 1'b0));

    // Back-pressure: port 0 response held while port 1 waits.
    bus.i_req_valid = 2'b01; bus.i_req_addr[0] = S + 4; bus.i_req_size[0] = 2'd2;
    bus.i_req_unsigned[0] = 1'b0; bus.i_rsp_ready = 2'b00;
    #1 chk("bp_acc", bus.o_req_ready, 2'b01);
    @(posedge clk); #1;
    bus.i_req_valid = 2'b10; bus.i_req_addr[1] = S + 8; bus.i_req_size[1] = 2'd2;
    bus.i_req_unsigned[1] = 1'b0;
    repeat (5) begin
      #1;
      chk("bp_rdy", bus.o_req_ready, 2'b00);
      chk("bp_vld", bus.o_rsp_valid, 2'b01);
      chk("bp_dat", bus.o_rsp_rdata, ref_read(S + 4, 2'd2, 1'b0));
      @(posedge clk); #1;
    end
    bus.i_rsp_ready = 2'b01;
    #1 chk("bp_hand", bus.o_req_ready, 2'b10);
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    chk("bp_vld1", bus.o_rsp_valid, 2'b10);
    chk("bp_dat1", bus.o_rsp_rdata, ref_read(S + 8, 2'd2, 1'b0));
    bus.i_rsp_ready = 2'b11;
    @(posedge clk); #1;

    // Streaming: 8 word reads in 9 cycles.
    cnt = 0;
    bus.i_req_valid = 2'b01; bus.i_req_size[0] = 2'd2; bus.i_req_unsigned[0] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c < 8) bus.i_req_addr[0] = S + 32'(4 * c);
      else bus.i_req_valid = 2'b00;
      #1;
      if (c < 8) chk("st_rdy", bus.o_req_ready, 2'b01);
      if (bus.o_rsp_valid[0]) begin
        chk("st_dat", bus.o_rsp_rdata, ref_read(S + 32'(4 * cnt), 2'd2, 1'b0));
        cnt++;
      end
      @(posedge clk); #1;
    end
    chk("st_cnt", cnt, 8);

    // Reset while a response is held: must clear without a clock edge.
    bus.i_req_valid = 2'b01; bus.i_req_addr[0] = S; bus.i_rsp_ready = 2'b00;
    @(posedge clk); #1;
    bus.i_req_valid = 2'b00;
    chk("mr_pre", bus.o_rsp_valid, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_vld", bus.o_rsp_valid, 2'b00);
    chk("mr_dat", bus.o_rsp_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Contention straight after reset: alternating vs. fixed priority.
    bus.i_req_valid = 2'b11; bus.i_rsp_ready = 2'b11;
    bus.i_req_addr[0] = S; bus.i_req_addr[1] = S + 4;
    bus.i_req_size[0] = 2'd2; bus.i_req_size[1] = 2'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", bus.o_req_ready, (k % 2) ? 2'b10 : 2'b01);
      chk("fx_gnt", bus_f.o_req_ready, 2'b01);
      @(posedge clk); #1;
    end
    bus.i_req_valid = 2'b00;
    @(posedge clk); #1;

    // Randomized traffic against the behavioural model.
    do_reset();
    pend = 2'b00; m_vld = 1'b0; m_own = 1'b0; m_last = 1'b1; m_err = 1'b0; m_dat = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          p_addr[p] = rand_addr();
          p_size[p] = 2'($urandom_range(0, 3));
          p_uns[p] = 1'($urandom_range(0, 1));
        end
        bus.i_req_addr[p] = p_addr[p];
        bus.i_req_size[p] = p_size[p];
        bus.i_req_unsigned[p] = p_uns[p];
      end
      bus.i_req_valid = pend;
      bus.i_rsp_ready = {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0};
      #1;
      chk("rnd_vld", bus.o_rsp_valid, m_vld ? (m_own ? 2'b10 : 2'b01) : 2'b00);
      if (m_vld) begin
        chk("rnd_dat", bus.o_rsp_rdata, m_dat);
        chk("rnd_err", bus.o_rsp_err, m_err);
      end
      free = !m_vld || bus.i_rsp_ready[m_own];
      pick = (pend == 2'b11) ? !m_last : pend[1];
      exp_rdy = (free && pend != 2'b00) ? (pick ? 2'b10 : 2'b01) : 2'b00;
      chk("rnd_rdy", bus.o_req_ready, exp_rdy);
      if (exp_rdy != 2'b00) begin
        {m_err, m_dat} = ref_read(p_addr[pick], p_size[pick], p_uns[pick]);
        m_vld = 1'b1; m_own = pick; m_last = pick; pend[pick] = 1'b0;
      end else if (free) begin
        m_vld = 1'b0;
      end
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule

// File: doc/rodata_arbiter.md
# rodata_arbiter

Two-port arbiter and access controller for the read-only data ROM. It shares one `rodata_mem` instance between the load/store unit (port 0) and the boot/debug copy path (port 1). It resolves contention round-robin, checks range and alignment, and extracts sign- or zero-extended byte, halfword or word results. Every response is registered and held until its requester accepts it.

## Interface
- `FIXED_PRIO`, default 0: 0 = round-robin arbitration; 1 = port 0 always wins contention.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  2  per-port request valid.
- `o_req_ready`  out  2  per-port request accept. At most one bit is set per cycle.
- `i_req_addr`  in  2×XLEN  per-port byte address.
- `i_req_size`  in  2×2  per-port `mem_size_t`: 00 byte, 01 half, 10 word, 11 illegal.
- `i_req_unsigned`  in  2  per-port zero-extend select (1 = zero-extend, 0 = sign-extend).
- `o_rsp_valid`  out  2  per-port response valid.
- `i_rsp_ready`  in  2  per-port response accept.
- `o_rsp_rdata`  out  XLEN  response data, shared by both ports.
- `o_rsp_err`  out  1  response error flag, shared by both ports.

## Operation
- **States.** `RA_IDLE` means no response is held. `RA_RESP` means one response is held for port `owner`.
- **Free condition.** The block is free when the state is `RA_IDLE`, or when the state is `RA_RESP` and `o_rsp_valid[owner] & i_rsp_ready[owner]` holds this cycle. This allows back-to-back accepts.
- **Arbitration.** The grant goes to the single valid port. On contention:
  - Round-robin mode: the port not granted last wins.
  - Fixed mode: port 0 wins.
  - `o_req_ready[g]` = free & `i_req_valid[g]`. Ready may depend on valid; a requester's valid must never depend on ready.
- **Last-grant pointer.** Updates only on an accepted request (valid & ready). It resets to 1, so port 0 wins the first contention.
- **Address decode.** The access is in range iff `ROM_MEM_START <= addr` and `addr + bytes - 1 <= ROM_MEM_END`. The ROM is driven with `addr - ROM_MEM_START` with bits [1:0] cleared.
- **Errors.** Any of the following sets err = 1 and rdata = 0:
  - out of range;
  - halfword with addr[0] = 1;
  - word with addr[1:0] ≠ 0;
  - size = 11.
- **Extraction** (lane = addr[1:0]):
  - Byte: `word[8*lane +: 8]`.
  - Half: `word[16*lane[1] +: 16]`.
  - Word: passed through unchanged.
  - Byte and half results are sign-extended to XLEN unless `i_req_unsigned` = 1.
- **Response registers.** On accept, rdata, err and owner are registered. `o_rsp_valid[owner]` rises and is held, with rdata and err stable, until `i_rsp_ready[owner]` is seen.
- **Exclusivity.** `o_rsp_valid` is never set for both ports at once.

## Timing
- **Reset values.** `o_rsp_valid` = 00, `o_rsp_rdata` = 0, `o_rsp_err` = 0, state = `RA_IDLE`, last-grant pointer = 1. `o_req_ready` is combinational and is 00 while no request is valid.
- **Latency.** A request accepted at edge N has its response valid after edge N (visible in cycle N+1). Sustained throughput is 1 access per cycle while the owner holds `i_rsp_ready` = 1.
- **Response stall.** `i_rsp_ready[owner]` = 0 holds both ports' `o_req_ready` at 0. Requests stay pending; no request is dropped.
- **Simultaneous events.** When a response handshake and a new accept occur in the same cycle, the new response replaces the old one at the next edge. Ownership may switch to the other port.
- **Reset mid-operation.** Asserting `i_rst_n` = 0 clears `o_rsp_valid` immediately (asynchronously). The pending response is discarded, and the requester must reissue it.
- **ROM path.** The ROM read path is combinational; the only register stage is the response register.

## Structure
- **Shared package `cotm32_pkg`:**
  - `mem_size_t` (`MEM_BYTE`, `MEM_HALF`, `MEM_WORD`);
  - `rodata_arb_state_t` (`RA_IDLE`, `RA_RESP`);
  - existing `XLEN`, `BYTE_WIDTH`, `ROM_MEM_START`, `ROM_MEM_END`, `ROM_MEM_SIZE`.
- **Sub-module.** `rodata_mem` is instantiated inside the block, with `DATA_WIDTH` = XLEN.
- **Local logic.** Extraction and error checks are local combinational logic, with no further sub-module.

## Test plan
ROM image word 0 = 0x80FF7F01. `S` = `ROM_MEM_START`.
- **Size and lane extraction.** Port 0 reads:
  - S word → 0x80FF7F01, err = 0;
  - S+1 byte unsigned → 0x0000007F;
  - S+3 byte signed → 0xFFFFFF80;
  - S+2 half signed → 0xFFFF80FF;
  - S+0 half unsigned → 0x00007F01.
- **Error cases.**
  - S+1 half → err = 1, rdata = 0.
  - S+2 word → err = 1.
  - `ROM_MEM_END`−1 word → err = 1.
  - size = 11 → err = 1.
  - addr `S`−4 → err = 1.
- **Round-robin contention.** Both ports hold valid for 4 accepts → grant order 0, 1, 0, 1. With `FIXED_PRIO` = 1 → 0, 0, 0, 0.
- **Back-pressure.** Port 0 response held with `i_rsp_ready[0]` = 0 for 5 cycles:
  - rdata stays stable;
  - `o_req_ready` = 00 throughout;
  - port 1's pending request is accepted in the same cycle `i_rsp_ready[0]` rises.
- **Streaming.** Continuous port 0 requests with `i_rsp_ready` held high → 8 words in 9 cycles.
- **Reset mid-operation.** Assert `i_rst_n` low while `o_rsp_valid` = 01 → `o_rsp_valid` goes to 00 without waiting for a clock edge. After release, port 0 wins the first contention.
